// File: rtl/apb_slave_mux_if.sv
// Bridge-side and peripheral-side APB signal bundle for apb_slave_mux.
// The bridge drives through "master"; the mux consumes it through "slave".
interface apb_slave_mux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             M_PSEL;
  logic                             M_PENABLE;
  logic [ADDR_WIDTH-1:0]            M_PADDR;
  logic                             M_PWRITE;
  logic [DATA_WIDTH-1:0]            M_PWDATA;
  logic [DATA_WIDTH-1:0]            M_PRDATA;
  logic                             M_PREADY;
  logic                             M_PSLVERR;

  logic [NUM_SLAVES-1:0]            S_PSEL;
  logic                             S_PENABLE;
  logic [ADDR_WIDTH-1:0]            S_PADDR;
  logic                             S_PWRITE;
  logic [DATA_WIDTH-1:0]            S_PWDATA;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_PRDATA;
  logic [NUM_SLAVES-1:0]            S_PREADY;
  logic [NUM_SLAVES-1:0]            S_PSLVERR;

  modport master (
    output M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA,
    input  M_PRDATA, M_PREADY, M_PSLVERR
  );

  modport slave (
    input  M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA,
    output M_PRDATA, M_PREADY, M_PSLVERR,
    output S_PSEL, S_PENABLE, S_PADDR, S_PWRITE, S_PWDATA,
    input  S_PRDATA, S_PREADY, S_PSLVERR
  );

  modport periph (
    input  S_PSEL, S_PENABLE, S_PADDR, S_PWRITE, S_PWDATA,
    output S_PRDATA, S_PREADY, S_PSLVERR
  );
endinterface

// File: rtl/apb_slave_mux.sv
// APB address decoder / response mux with default error slave and a
// per-transfer stall watchdog that records the address of aborted accesses.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for a setup phase
// ACCESS | transfer in access phase, stall counter running
// TOUT   | one-cycle forced error completion after a stall abort
module apb_slave_mux #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter int                    SLOT_SHIFT     = 12,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  apb_slave_mux_if.slave        bus,
  output logic                  tout_flag,
  output logic [ADDR_WIDTH-1:0] tout_addr,
  input  logic                  tout_clr
);

  localparam int IDX_W   = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
  localparam int TOP_LSB = SLOT_SHIFT + IDX_W;
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W:0]   NS_LIM   = (IDX_W+1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_TOUT   = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tout_flag;
  logic [ADDR_WIDTH-1:0] r_tout_addr;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_hit;
  logic                  w_tout;
  logic                  w_access;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_rdy_sel;
  logic                  w_err_sel;
  logic [DATA_WIDTH-1:0] w_rdata_sel;

  assign w_idx    = bus.M_PADDR[TOP_LSB-1:SLOT_SHIFT];
  assign w_hit    = (bus.M_PADDR[ADDR_WIDTH-1:TOP_LSB] == BASE_ADDR[ADDR_WIDTH-1:TOP_LSB])
                    && ({1'b0, w_idx} < NS_LIM);
  assign w_tout   = (r_state == S_TOUT);
  assign w_access = bus.M_PSEL & bus.M_PENABLE;

  // Loop-based select keeps out-of-range indices from ever addressing a slice.
  always_comb begin
    w_onehot    = '0;
    w_rdy_sel   = 1'b0;
    w_err_sel   = 1'b0;
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_rdy_sel   = bus.S_PREADY[i];
        w_err_sel   = bus.S_PSLVERR[i];
        w_rdata_sel = bus.S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.S_PSEL    = (bus.M_PSEL && w_hit && !w_tout) ? w_onehot : '0;
  assign bus.S_PENABLE = bus.M_PENABLE;
  assign bus.S_PADDR   = bus.M_PADDR;
  assign bus.S_PWRITE  = bus.M_PWRITE;
  assign bus.S_PWDATA  = bus.M_PWDATA;

  assign bus.M_PREADY  = w_access & (w_tout | !w_hit | w_rdy_sel);
  assign bus.M_PSLVERR = w_access & (w_tout | !w_hit | (w_rdy_sel & w_err_sel));
  assign bus.M_PRDATA  = (w_hit && !w_tout) ? w_rdata_sel : '0;

  assign tout_flag = r_tout_flag;
  assign tout_addr = r_tout_addr;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tout_flag <= 1'b0;
      r_tout_addr <= '0;
    end else begin
      if (tout_clr) r_tout_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.M_PSEL && !bus.M_PENABLE) begin
            r_state <= S_ACCESS;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (!bus.M_PSEL || !w_hit || w_rdy_sel) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Later assignment overrides a same-cycle clear.
            if (r_cnt == CNT_LAST) begin
              r_state     <= S_TOUT;
              r_tout_flag <= 1'b1;
              r_tout_addr <= bus.M_PADDR;
            end
          end
        end
        S_TOUT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mux.sv
// Scoreboard bench for apb_slave_mux: expected completions are queued when a
// transfer is launched and compared when the mux returns PREADY.
module tb_apb_slave_mux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cycles;
  } exp_t;

  logic          HCLK;
  logic          HRESETn;
  logic          tout_flag;
  logic [AW-1:0] tout_addr;
  logic          tout_clr;

  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  apb_slave_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  apb_slave_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .BASE_ADDR(32'h4000_0000), .SLOT_SHIFT(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .tout_flag(tout_flag), .tout_addr(tout_addr), .tout_clr(tout_clr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input logic clr);
    drive_edge();
    bus.M_PSEL    = 1'b0;
    bus.M_PENABLE = 1'b0;
    bus.S_PREADY  = '0;
    bus.S_PSLVERR = '0;
    tout_clr      = clr;
    @(negedge HCLK);
    chk("idle_psel", 64'(bus.S_PSEL), 64'd0);
    chk("idle_pready", 64'(bus.M_PREADY), 64'd0);
  endtask

  // slv < 0: unmapped; waits < 0: slave never ready; clr_k/rst_k: access
  // cycle (0-based) in which tout_clr or reset is asserted, -1 for none.
  task automatic xfer(input string tag, input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wdata, input int slv, input int waits,
                      input logic [DW-1:0] rdata, input logic err,
                      input int clr_k, input int rst_k);
    exp_t       e;
    logic [NS-1:0] oh;
    bit         tmo;
    bit         done;
    oh  = (slv >= 0) ? NS'(1 << slv) : '0;
    tmo = (slv >= 0) && (waits < 0 || waits >= TO);
    e.cycles = (slv < 0) ? 1 : (tmo ? TO + 1 : waits + 1);
    e.err    = (slv < 0 || tmo) ? 1'b1 : err;
    e.rdata  = (slv < 0 || tmo) ? '0 : rdata;
    if (rst_k < 0) sb.push_back(e);

    drive_edge();
    tout_clr      = 1'b0;
    bus.M_PSEL    = 1'b1;
    bus.M_PENABLE = 1'b0;
    bus.M_PADDR   = addr;
    bus.M_PWRITE  = wr;
    bus.M_PWDATA  = wdata;
    bus.S_PREADY  = ~oh;
    bus.S_PSLVERR = ~oh | (err ? oh : '0);
    for (int i = 0; i < NS; i++)
      bus.S_PRDATA[i*DW +: DW] = (i == slv) ? rdata : (32'hBAD0_0000 | 32'(i));
    @(negedge HCLK);
    chk({tag, "_psel_setup"}, 64'(bus.S_PSEL), 64'(oh));
    chk({tag, "_passthru"}, {bus.S_PADDR, bus.S_PWDATA[30:0], bus.S_PWRITE},
        {addr, wdata[30:0], wr});

    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      drive_edge();
      bus.M_PENABLE = 1'b1;
      tout_clr      = (k == clr_k);
      HRESETn       = !(k == rst_k);
      if (slv >= 0 && waits >= 0 && k >= waits) bus.S_PREADY = '1;
      @(negedge HCLK);
      chk({tag, "_psel_access"}, 64'(bus.S_PSEL), (tmo && k == TO) ? 64'd0 : 64'(oh));
      if (k == rst_k) begin
        drive_edge();
        HRESETn       = 1'b1;
        tout_clr      = 1'b0;
        bus.M_PSEL    = 1'b0;
        bus.M_PENABLE = 1'b0;
        done = 1;
      end else if (bus.M_PREADY) begin
        done = 1;
        chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_cycles"}, 64'(k + 1), 64'(e.cycles));
          chk({tag, "_prdata"}, 64'(bus.M_PRDATA), 64'(e.rdata));
          chk({tag, "_pslverr"}, 64'(bus.M_PSLVERR), 64'(e.err));
        end
      end
    end
    chk({tag, "_completed"}, 64'(done), 64'd1);
    if (!done && sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    HRESETn       = 1'b0;
    tout_clr      = 1'b0;
    bus.M_PSEL    = 1'b0;
    bus.M_PENABLE = 1'b0;
    bus.M_PADDR   = '0;
    bus.M_PWRITE  = 1'b0;
    bus.M_PWDATA  = '0;
    bus.S_PRDATA  = '0;
    bus.S_PREADY  = '0;
    bus.S_PSLVERR = '0;
    drive_edge();
    @(negedge HCLK);
    chk("rst_flag", 64'(tout_flag), 64'd0);
    chk("rst_addr", 64'(tout_addr), 64'd0);
    chk("rst_psel", 64'(bus.S_PSEL), 64'd0);
    chk("rst_pready", 64'(bus.M_PREADY), 64'd0);
    drive_edge();
    HRESETn = 1'b1;
    idle(1'b0);

    xfer("rd1", 32'h4000_1004, 1'b0, 32'h0, 1, 2, 32'hA5A5_1234, 1'b0, -1, -1);
    idle(1'b0);
    chk("rd1_flag", 64'(tout_flag), 64'd0);

    xfer("unmap", 32'h5000_0000, 1'b1, 32'h1111_2222, -1, 0, 32'h0, 1'b0, -1, -1);
    idle(1'b0);
    chk("unmap_flag", 64'(tout_flag), 64'd0);

    xfer("tout", 32'h4000_2008, 1'b1, 32'hCAFE_F00D, 2, -1, 32'h2222_0000, 1'b0, -1, -1);
    idle(1'b0);
    chk("tout_flag", 64'(tout_flag), 64'd1);
    chk("tout_addr", 64'(tout_addr), 64'h4000_2008);

    idle(1'b1);
    idle(1'b0);
    chk("clr_flag", 64'(tout_flag), 64'd0);
    chk("clr_addr_hold", 64'(tout_addr), 64'h4000_2008);

    xfer("b2b0", 32'h4000_0000, 1'b0, 32'h0, 0, 0, 32'h0000_0B0B, 1'b0, -1, -1);
    xfer("b2b3", 32'h4000_3000, 1'b1, 32'h3030_3030, 3, 0, 32'h0303_0303, 1'b0, -1, -1);
    idle(1'b0);

    xfer("err3", 32'h4000_3010, 1'b0, 32'h0, 3, 1, 32'h3333_0000, 1'b1, -1, -1);
    idle(1'b0);
    chk("err3_flag", 64'(tout_flag), 64'd0);

    xfer("race", 32'h4000_1020, 1'b1, 32'h5555_AAAA, 1, -1, 32'h1111_0000, 1'b0, TO - 1, -1);
    idle(1'b0);
    chk("race_flag", 64'(tout_flag), 64'd1);
    chk("race_addr", 64'(tout_addr), 64'h4000_1020);
    idle(1'b1);
    idle(1'b0);
    chk("race_clr_flag", 64'(tout_flag), 64'd0);

    xfer("rst", 32'h4000_2000, 1'b0, 32'h0, 2, -1, 32'h2222_1111, 1'b0, -1, 4);
    idle(1'b0);
    chk("rst_mid_flag", 64'(tout_flag), 64'd0);
    chk("rst_mid_addr", 64'(tout_addr), 64'd0);
    xfer("post_rst", 32'h4000_2004, 1'b0, 32'h0, 2, 3, 32'h7777_8888, 1'b0, -1, -1);
    idle(1'b0);
    xfer("post_rst_tout", 32'h4000_0FFC, 1'b0, 32'h0, 0, -1, 32'h0F0F_0F0F, 1'b0, -1, -1);
    idle(1'b0);
    chk("post_rst_tout_flag", 64'(tout_flag), 64'd1);
    chk("post_rst_tout_addr", 64'(tout_addr), 64'h4000_0FFC);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_slave_mux.md
Name: apb_slave_mux

Overview:
- Sits directly downstream of the AHB-to-APB bridge and consumes its APB master interface.
- Decodes the APB address into one of NUM_SLAVES peripheral windows and fans out PSEL.
- Muxes the selected slave's PRDATA, PREADY and PSLVERR back to the bridge.
- Unmapped addresses are answered by an internal default slave with an error response.
- A per-transfer watchdog aborts any access stalled longer than TIMEOUT_CYCLES and records the failing address in sticky status.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
NUM_SLAVES, 4, number of downstream APB slaves (2..16)
BASE_ADDR, 32'h4000_0000, base of peripheral region; bits below SLOT_SHIFT+IDX_W ignored
SLOT_SHIFT, 12, log2 of window size per slave (4 KB)
TIMEOUT_CYCLES, 16, max access-phase cycles without PREADY before abort (>=2)

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
M_PSEL  in  1  from bridge
M_PENABLE  in  1  from bridge
M_PADDR  in  ADDR_WIDTH  from bridge
M_PWRITE  in  1  from bridge
M_PWDATA  in  DATA_WIDTH  from bridge
M_PRDATA  out  DATA_WIDTH  to bridge
M_PREADY  out  1  to bridge
M_PSLVERR  out  1  to bridge
S_PSEL  out  NUM_SLAVES  one-hot slave selects
S_PENABLE  out  1  shared, equals M_PENABLE
S_PADDR  out  ADDR_WIDTH  shared, equals M_PADDR
S_PWRITE  out  1  shared, equals M_PWRITE
S_PWDATA  out  DATA_WIDTH  shared, equals M_PWDATA
S_PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i in slice [i*DATA_WIDTH +: DATA_WIDTH]
S_PREADY  in  NUM_SLAVES  per-slave ready
S_PSLVERR  in  NUM_SLAVES  per-slave error
tout_flag  out  1  sticky timeout status
tout_addr  out  ADDR_WIDTH  M_PADDR of the last timed-out transfer
tout_clr  in  1  single-cycle clear of tout_flag

Behaviour:
- Decode (combinational):
  - IDX_W = max(1, clog2(NUM_SLAVES)).
  - idx = M_PADDR[SLOT_SHIFT+IDX_W-1:SLOT_SHIFT].
  - hit = (M_PADDR[ADDR_WIDTH-1:SLOT_SHIFT+IDX_W] == BASE_ADDR[ADDR_WIDTH-1:SLOT_SHIFT+IDX_W]) && idx < NUM_SLAVES.
- Shared signals S_PENABLE/S_PADDR/S_PWRITE/S_PWDATA are pure pass-through, zero latency.
- S_PSEL[idx] = M_PSEL && hit && state!=TOUT; all other S_PSEL bits are 0; at most one bit is ever high.
- FSM states: IDLE, ACCESS, TOUT. Registers: state, cnt (clog2(TIMEOUT_CYCLES)+1 bits), tout_flag, tout_addr.
  - IDLE: M_PSEL && !M_PENABLE (setup) -> ACCESS, cnt<=0.
  - ACCESS, response ready (mapped S_PREADY[idx]=1, or unmapped): -> IDLE.
  - ACCESS, mapped and S_PREADY[idx]=0: cnt<=cnt+1; when cnt==TIMEOUT_CYCLES-1 -> TOUT.
  - ACCESS, M_PSEL=0 (master dropped transfer): -> IDLE.
  - TOUT: lasts exactly one cycle -> IDLE.
  - Back-to-back: after a completion the bridge presents setup on the next cycle; IDLE accepts it immediately, giving no dead cycle.
- Response mux (combinational):
  - M_PREADY = 0 unless M_PSEL && M_PENABLE. In that case:
    - TOUT: 1.
    - Unmapped: 1.
    - Mapped: S_PREADY[idx].
  - M_PSLVERR:
    - TOUT: 1.
    - Unmapped: 1.
    - Mapped: S_PSLVERR[idx] gated by M_PREADY.
  - M_PRDATA:
    - Mapped and not TOUT: selected slice.
    - Otherwise: 0.
- Timeout latency: the slave sees TIMEOUT_CYCLES access cycles; the bridge sees PREADY=1/PSLVERR=1 in access cycle TIMEOUT_CYCLES+1, with S_PSEL already deasserted in that cycle.
- Status:
  - On entering TOUT: tout_flag<=1, tout_addr<=M_PADDR.
  - tout_clr clears tout_flag only; tout_addr holds its value.
  - Simultaneous set and clear: set wins.
- Unmapped transfers do not set tout_flag.
- Reset (synchronous, HRESETn=0 at posedge):
  - state=IDLE, cnt=0, tout_flag=0, tout_addr=0.
  - Reset mid-ACCESS or mid-TOUT abandons the transfer without a timeout record.
  - Combinational outputs continue to follow the inputs.

Test Plan:
- Mapped read: M_PADDR=0x4000_1004; slave 1 holds PREADY low 2 access cycles, then PREADY=1 with PRDATA=0xA5A5_1234 -> S_PSEL=4'b0010 throughout; M_PREADY=1 and M_PRDATA=0xA5A5_1234 on the 3rd access cycle; M_PSLVERR=0.
- Unmapped write: M_PADDR=0x5000_0000 -> S_PSEL=0; M_PREADY=1, M_PSLVERR=1 on the 1st access cycle; tout_flag stays 0.
- Timeout: write to 0x4000_2008, slave 2 never ready, TIMEOUT_CYCLES=16 -> S_PSEL[2] high for setup plus 16 access cycles; 17th access cycle shows M_PREADY=1, M_PSLVERR=1, S_PSEL=0; tout_flag=1 and tout_addr=0x4000_2008 from the following cycle.
- Back-to-back: read slave 0 then write slave 3 (0x4000_3000), both zero-wait -> second setup accepted on the cycle after the first completion; S_PSEL sequence 0001, 0001, 1000, 1000.
- Slave error plus status race: slave 3 returns PSLVERR=1 with PREADY -> M_PSLVERR=1 and tout_flag unaffected; then tout_clr pulsed on the same cycle as a new TOUT entry -> tout_flag remains 1.
- Reset mid-access: HRESETn low for 1 cycle during the 5th stalled access cycle -> state IDLE and cnt 0 afterwards; no TOUT and no tout_flag; the next transfer completes normally.
